// File: rtl/radix4_booth_mul.sv
// Purpose : sequential unsigned DW x DW multiplier, radix-4 (modified Booth) recoding, one digit per cycle.
// Latency : fixed; mulfinish is high in the (DW/2+2)th cycle after the edge that accepts start (18 for DW=32).
// Backpressure: none queued; start is only sampled in IDLE, ignored while mulbusy is high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset; aborts any multiply in flight
//   start        request, sampled only in IDLE
//   multiplicand unsigned operand X, captured on the accepting edge
//   multiplier   unsigned operand Y, captured on the accepting edge
//   product      registered X*Y; valid from the FINISH cycle until the next accepted start
//   mulfinish    one-cycle pulse, high in the FINISH state
//   mulbusy      high in the MUL and FINISH states

module radix4_booth_mul #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     multiplicand,
    input  logic [DW-1:0]     multiplier,
    output logic [2*DW-1:0]   product,
    output logic              mulfinish,
    output logic              mulbusy
);

    // Digit count: the multiplier is zero-extended by two bits so the top
    // Booth digit is never negative, which takes DW/2+1 digits.
    localparam int N  = DW / 2 + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    // Accumulator carries four guard bits so the two's complement partial
    // sums (which can dip negative) never wrap into the product field.
    localparam int AW = 2 * DW + 4;
    // Multiplier window: {2'b00, Y, 1'b0}; the appended zero is Y'[-1].
    localparam int YW = DW + 3;

    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [CW-1:0]  counter;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  acc_nxt;
    // Multiplicand pre-shifted by 2i, so digit i's weight is applied by
    // shifting two places per cycle instead of a barrel shifter.
    logic [AW-1:0]  x_sh;
    // Multiplier window shifted right two places per cycle; bits [2:0]
    // always hold {Y'[2i+1], Y'[2i], Y'[2i-1]} for the current digit.
    logic [YW-1:0]  y_win;

    logic [2:0]     triplet;
    logic           dig_zero;
    logic           dig_two;
    logic           dig_neg;
    logic [AW-1:0]  pp_mag;
    logic           last_digit;

    assign triplet    = y_win[2:0];
    assign last_digit = (counter == LAST_CNT);

    // ------------------------------------------------------------------
    // Booth digit decode
    //   000,111 -> 0   001,010 -> +1   011 -> +2   100 -> -2   101,110 -> -1
    // ------------------------------------------------------------------
    always_comb begin
        dig_zero = 1'b0;
        dig_two  = 1'b0;
        dig_neg  = 1'b0;
        case (triplet)
            3'b000, 3'b111: dig_zero = 1'b1;
            3'b001, 3'b010: begin
                dig_two = 1'b0;
                dig_neg = 1'b0;
            end
            3'b011: dig_two = 1'b1;
            3'b100: begin
                dig_two = 1'b1;
                dig_neg = 1'b1;
            end
            3'b101, 3'b110: dig_neg = 1'b1;
            default: dig_zero = 1'b1;
        endcase
    end

    // Partial product magnitude |digit| * X * 4^i, then add or subtract.
    always_comb begin
        pp_mag = '0;
        if (!dig_zero) begin
            pp_mag = dig_two ? (x_sh << 1) : x_sh;
        end
        acc_nxt = dig_neg ? (acc - pp_mag) : (acc + pp_mag);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_MUL;
            S_MUL:    if (last_digit) state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mulfinish = 1'b0;
        mulbusy   = 1'b0;
        case (state)
            S_MUL:    mulbusy = 1'b1;
            S_FINISH: begin
                mulbusy   = 1'b1;
                mulfinish = 1'b1;
            end
            default: begin
                mulfinish = 1'b0;
                mulbusy   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            acc     <= '0;
            x_sh    <= '0;
            y_win   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_sh    <= {{(AW - DW){1'b0}}, multiplicand};
                        y_win   <= {2'b00, multiplier, 1'b0};
                        acc     <= '0;
                        counter <= '0;
                    end
                end
                S_MUL: begin
                    acc   <= acc_nxt;
                    x_sh  <= x_sh << 2;
                    y_win <= y_win >> 2;
                    if (last_digit) begin
                        // Loaded on the edge entering FINISH so product is
                        // already valid while mulfinish is high.
                        product <= acc_nxt[2*DW-1:0];
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                default: begin
                    counter <= counter;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_radix4_booth_mul.sv
module tb_radix4_booth_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        mulfinish;
    logic        mulbusy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    radix4_booth_mul #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .mulfinish    (mulfinish),
        .mulbusy      (mulbusy)
    );

    function automatic logic [31:0] fx(input int k);
        return 32'h0100_0003 + 32'(k) * 32'h0011_0101;
    endfunction

    function automatic logic [31:0] gy(input int k);
        return 32'hF000_0001 - 32'(k) * 32'h0003_0005;
    endfunction

    // Issues one multiply from IDLE and waits (bounded) for mulfinish.
    // cyc = negedges after the accepting edge until mulfinish seen (40 = timeout).
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [63:0] p, output int cyc, output logic [3:0] hi);
        @(negedge clk);
        multiplicand = x;
        multiplier   = y;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = ~x;
        multiplier   = y ^ 32'hDEAD_BEEF;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mulfinish) break;
        end
        p  = product;
        hi = dut.acc[67:64];
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        tests++; if (product !== 64'd0) begin fails++; $display("FAIL reset_product: got %h expected 0", product); end
        tests++; if (mulfinish !== 1'b0) begin fails++; $display("FAIL reset_mulfinish: got %b expected 0", mulfinish); end
        tests++; if (mulbusy !== 1'b0) begin fails++; $display("FAIL reset_mulbusy: got %b expected 0", mulbusy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [63:0] p; int cyc; logic [3:0] hi;
        run_op(32'h0000_0000, 32'h1234_5678, p, cyc, hi);
        tests++; if (p !== 64'd0) begin fails++; $display("FAIL zero_product: got %h expected 0", p); end
        tests++; if (cyc != 18) begin fails++; $display("FAIL zero_latency: got %0d expected 18", cyc); end
        tests++; if (hi !== 4'd0) begin fails++; $display("FAIL zero_acc_hi: got %h expected 0", hi); end
    endtask

    task automatic test_all_ones();
        logic [63:0] p; int cyc; logic [3:0] hi;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, cyc, hi);
        tests++; if (p !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL ones_product: got %h expected fffffffe00000001", p); end
        tests++; if (cyc != 18) begin fails++; $display("FAIL ones_latency: got %0d expected 18", cyc); end
        tests++; if (hi !== 4'd0) begin fails++; $display("FAIL ones_acc_hi: got %h expected 0", hi); end
        @(negedge clk);
        tests++; if (mulfinish !== 1'b0) begin fails++; $display("FAIL ones_pulse_width: got %b expected 0", mulfinish); end
        repeat (3) @(negedge clk);
        tests++; if (product !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL ones_hold: got %h expected fffffffe00000001", product); end
    endtask

    task automatic test_edges();
        logic [31:0] xs [5] = '{32'hAAAA_AAAA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FFFF};
        logic [31:0] ys [5] = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0010, 32'h0000_FFFF};
        logic [63:0] es [5] = '{64'h0000_0001_FFFF_FFFE, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
                               64'h0000_0001_2345_6780, 64'h0000_0000_FFFE_0001};
        logic [63:0] p; int cyc; logic [3:0] hi;
        for (int i = 0; i < 5; i++) begin
            run_op(xs[i], ys[i], p, cyc, hi);
            tests++; if (p !== es[i]) begin fails++; $display("FAIL edge_product[%0d]: got %h expected %h", i, p, es[i]); end
            tests++; if (cyc != 18) begin fails++; $display("FAIL edge_latency[%0d]: got %0d expected 18", i, cyc); end
        end
    endtask

    task automatic test_back_to_back();
        int          pulses = 0;
        int          pk [2] = '{-1, -1};
        logic [63:0] pp [2] = '{64'd0, 64'd0};
        logic [63:0] e0, e1, e2;
        bit          seen;
        e0 = {32'd0, fx(0)}  * {32'd0, gy(0)};
        e1 = {32'd0, fx(19)} * {32'd0, gy(19)};
        e2 = {32'd0, fx(38)} * {32'd0, gy(38)};
        repeat (2) @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 18) begin
                tests++; if (mulbusy !== 1'b1) begin fails++; $display("FAIL b2b_busy_finish: got %b expected 1", mulbusy); end
            end
            if (k == 19) begin
                tests++; if (mulbusy !== 1'b0) begin fails++; $display("FAIL b2b_busy_idle: got %b expected 0", mulbusy); end
            end
            if (mulfinish) begin
                if (pulses < 2) begin pk[pulses] = k; pp[pulses] = product; end
                pulses++;
            end
            multiplicand = fx(k);
            multiplier   = gy(k);
            start        = 1'b1;
        end
        start = 1'b0;
        tests++; if (pulses != 2) begin fails++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
        tests++; if (pk[0] != 18) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 18", pk[0]); end
        tests++; if (pk[1] - pk[0] != 19) begin fails++; $display("FAIL b2b_spacing: got %0d expected 19", pk[1] - pk[0]); end
        tests++; if (pp[0] !== e0) begin fails++; $display("FAIL b2b_result0: got %h expected %h", pp[0], e0); end
        tests++; if (pp[1] !== e1) begin fails++; $display("FAIL b2b_result1: got %h expected %h", pp[1], e1); end
        // Operation accepted on edge 38 completes after the window.
        seen = 1'b0;
        for (int k = 40; k < 70 && !seen; k++) begin
            @(negedge clk);
            if (mulfinish) seen = 1'b1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL b2b_third_timeout: got no pulse expected pulse"); end
        tests++; if (product !== e2) begin fails++; $display("FAIL b2b_result2: got %h expected %h", product, e2); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] p_before; logic [63:0] p; int cyc; logic [3:0] hi; int pulses = 0;
        repeat (2) @(negedge clk);
        p_before = product;
        @(negedge clk);
        multiplicand = 32'h0BAD_F00D; multiplier = 32'h1357_9BDF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        tests++; if (mulbusy !== 1'b1) begin fails++; $display("FAIL rst_busy_before: got %b expected 1", mulbusy); end
        tests++; if (product !== p_before) begin fails++; $display("FAIL rst_hold_in_mul: got %h expected %h", product, p_before); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (mulbusy !== 1'b0) begin fails++; $display("FAIL rst_busy_after: got %b expected 0", mulbusy); end
        tests++; if (mulfinish !== 1'b0) begin fails++; $display("FAIL rst_finish_after: got %b expected 0", mulfinish); end
        tests++; if (product !== 64'd0) begin fails++; $display("FAIL rst_product_after: got %h expected 0", product); end
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (mulfinish) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL rst_no_finish: got %0d pulses expected 0", pulses); end
        run_op(32'd7, 32'd9, p, cyc, hi);
        tests++; if (p !== 64'd63) begin fails++; $display("FAIL rst_fresh_product: got %h expected 3f", p); end
        tests++; if (cyc != 18) begin fails++; $display("FAIL rst_fresh_latency: got %0d expected 18", cyc); end
    endtask

    task automatic test_random();
        logic [31:0] x, y; logic [63:0] e, p; int cyc; logic [3:0] hi;
        for (int i = 0; i < 2000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 16 == 0) x = 32'hFFFF_FFFF;
            if (i % 16 == 1) y = 32'hFFFF_FFFF;
            e = {32'd0, x} * {32'd0, y};
            run_op(x, y, p, cyc, hi);
            tests++; if (p !== e) begin fails++; $display("FAIL rand_product[%0d]: x=%h y=%h got %h expected %h", i, x, y, p, e); end
            tests++; if (hi !== 4'd0) begin fails++; $display("FAIL rand_acc_hi[%0d]: got %h expected 0", i, hi); end
            tests++; if (cyc != 18) begin fails++; $display("FAIL rand_latency[%0d]: got %0d expected 18", i, cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_all_ones();
        test_edges();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
